// File: rtl/ghost_collision_unit.sv
// ghost_collision_unit
// Per-tick collision resolver between Pac-Man and the four ghosts.
// On i_tick (in IDLE) all tile positions and ghost states are snapshotted,
// the ghosts are scanned one per cycle (SCAN0..SCAN3), and RESOLVE decides
// between a death pulse, a single ghost-eaten pulse with score, or nothing.
// An eat optionally freezes the playfield for FREEZE_CYCLES cycles.
//
// Optional feature macro: GHOST_COLLISION_CROSS_EN
//   Defined: the previous tick's snapshot is also kept and a ghost matches
//   when it and Pac-Man swapped tiles between ticks.
//   Undefined: current-tile equality only.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_tick                         movement-tick strobe
//   i_ghost_reload                 level/life restart, synchronous clear
//   i_energizers_eaten             restarts the eat chain
//   i_pac_x/y, i_<ghost>_x/y       tile coordinates
//   i_<ghost>_state                ghost mode (4-bit)
//   o_<ghost>_eaten                one-cycle eaten pulse
//   o_pacman_dead                  one-cycle death pulse
//   o_score_valid, o_score_add     one-cycle score strobe and points
//   o_freeze                       post-eat freeze active
//   o_busy                         high in every state except IDLE
module ghost_collision_unit #(
  parameter int unsigned FREEZE_CYCLES = 50000000,
  parameter int unsigned TILE_W        = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_ghost_reload,
  input  logic              i_energizers_eaten,
  input  logic [TILE_W-1:0] i_pac_x,
  input  logic [TILE_W-1:0] i_pac_y,
  input  logic [TILE_W-1:0] i_blinky_x,
  input  logic [TILE_W-1:0] i_blinky_y,
  input  logic [TILE_W-1:0] i_pinky_x,
  input  logic [TILE_W-1:0] i_pinky_y,
  input  logic [TILE_W-1:0] i_inky_x,
  input  logic [TILE_W-1:0] i_inky_y,
  input  logic [TILE_W-1:0] i_clyde_x,
  input  logic [TILE_W-1:0] i_clyde_y,
  input  logic [3:0]        i_blinky_state,
  input  logic [3:0]        i_pinky_state,
  input  logic [3:0]        i_inky_state,
  input  logic [3:0]        i_clyde_state,
  output logic              o_blinky_eaten,
  output logic              o_pinky_eaten,
  output logic              o_inky_eaten,
  output logic              o_clyde_eaten,
  output logic              o_pacman_dead,
  output logic              o_score_valid,
  output logic [11:0]       o_score_add,
  output logic              o_freeze,
  output logic              o_busy
);

  // Ghost mode encodings shared with the ghost mode controller (params.vh)
  localparam logic [3:0]  GST_SCATTER = 4'd0;
  localparam logic [3:0]  GST_CHASE   = 4'd1;
  localparam logic [3:0]  GST_FRIGHT  = 4'd2;
  localparam logic [11:0] SCORE_BASE  = 12'd200;
  localparam logic [31:0] FRZ_LAST    = 32'(FREEZE_CYCLES - 32'd1);

  // SCANk encodes k in the low two bits so the state doubles as ghost index
  typedef enum logic [2:0] {
    S_SCAN0   = 3'd0,
    S_SCAN1   = 3'd1,
    S_SCAN2   = 3'd2,
    S_SCAN3   = 3'd3,
    S_IDLE    = 3'd4,
    S_RESOLVE = 3'd5,
    S_FREEZE  = 3'd6,
    S_DEAD    = 3'd7
  } state_e;

  logic [TILE_W-1:0] in_gx [4];
  logic [TILE_W-1:0] in_gy [4];
  logic [3:0]        in_gst [4];

  assign in_gx[0] = i_blinky_x;  assign in_gy[0] = i_blinky_y;  assign in_gst[0] = i_blinky_state;
  assign in_gx[1] = i_pinky_x;   assign in_gy[1] = i_pinky_y;   assign in_gst[1] = i_pinky_state;
  assign in_gx[2] = i_inky_x;    assign in_gy[2] = i_inky_y;    assign in_gst[2] = i_inky_state;
  assign in_gx[3] = i_clyde_x;   assign in_gy[3] = i_clyde_y;   assign in_gst[3] = i_clyde_state;

  state_e            state_q, state_d;
  logic [TILE_W-1:0] px_q, px_d, py_q, py_d;
  logic [TILE_W-1:0] gx_q [4];
  logic [TILE_W-1:0] gx_d [4];
  logic [TILE_W-1:0] gy_q [4];
  logic [TILE_W-1:0] gy_d [4];
  logic [3:0]        gst_q [4];
  logic [3:0]        gst_d [4];
  logic [3:0]        kill_q, kill_d, eat_q, eat_d;
  logic [1:0]        chain_q, chain_d;
  logic [31:0]       frz_cnt_q, frz_cnt_d;
  logic [3:0]        eaten_q, eaten_d;
  logic              dead_q, dead_d;
  logic              score_vld_q, score_vld_d;
  logic [11:0]       score_add_q, score_add_d;
  logic              freeze_q, freeze_d;
  logic              busy_q, busy_d;
`ifdef GHOST_COLLISION_CROSS_EN
  logic [TILE_W-1:0] ppx_q, ppx_d, ppy_q, ppy_d;
  logic [TILE_W-1:0] pgx_q [4];
  logic [TILE_W-1:0] pgx_d [4];
  logic [TILE_W-1:0] pgy_q [4];
  logic [TILE_W-1:0] pgy_d [4];
`endif

  logic [1:0] idx;
  logic       tile_hit, gst_live, gst_fright;

  // Match test for the ghost selected by the current SCANk state
  always_comb begin
    idx        = state_q[1:0];
    tile_hit   = (gx_q[idx] == px_q) && (gy_q[idx] == py_q);
`ifdef GHOST_COLLISION_CROSS_EN
    tile_hit   = tile_hit ||
                 ((px_q == pgx_q[idx]) && (py_q == pgy_q[idx]) &&
                  (gx_q[idx] == ppx_q) && (gy_q[idx] == ppy_q));
`endif
    gst_live   = (gst_q[idx] == GST_CHASE) || (gst_q[idx] == GST_SCATTER);
    gst_fright = (gst_q[idx] == GST_FRIGHT);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    gst_d       = gst_q;
    kill_d      = kill_q;
    eat_d       = eat_q;
    chain_d     = chain_q;
    frz_cnt_d   = frz_cnt_q;
    eaten_d     = 4'd0;
    dead_d      = 1'b0;
    score_vld_d = 1'b0;
    score_add_d = 12'd0;
`ifdef GHOST_COLLISION_CROSS_EN
    ppx_d       = ppx_q;
    ppy_d       = ppy_q;
    pgx_d       = pgx_q;
    pgy_d       = pgy_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_tick) begin
`ifdef GHOST_COLLISION_CROSS_EN
          ppx_d = px_q;
          ppy_d = py_q;
          pgx_d = gx_q;
          pgy_d = gy_q;
`endif
          px_d    = i_pac_x;
          py_d    = i_pac_y;
          gx_d    = in_gx;
          gy_d    = in_gy;
          gst_d   = in_gst;
          kill_d  = 4'd0;
          eat_d   = 4'd0;
          state_d = S_SCAN0;
        end
      end
      S_SCAN0, S_SCAN1, S_SCAN2, S_SCAN3: begin
        if (tile_hit && gst_live)   kill_d[idx] = 1'b1;
        if (tile_hit && gst_fright) eat_d[idx]  = 1'b1;
        state_d = (state_q == S_SCAN3) ? S_RESOLVE : state_e'(state_q + 3'd1);
      end
      S_RESOLVE: begin
        if (|kill_q) begin
          dead_d  = 1'b1;
          state_d = S_DEAD;
        end else if (|eat_q) begin
          // Only the lowest-index ghost is eaten; the rest re-detect next tick
          eaten_d     = eat_q & (~eat_q + 4'd1);
          score_vld_d = 1'b1;
          score_add_d = SCORE_BASE << chain_q;
          chain_d     = (chain_q == 2'd3) ? 2'd3 : chain_q + 2'd1;
          state_d     = (FREEZE_CYCLES == 0) ? S_IDLE : S_FREEZE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FREEZE: begin
        if (frz_cnt_q == FRZ_LAST) begin
          frz_cnt_d = 32'd0;
          state_d   = S_IDLE;
        end else begin
          frz_cnt_d = frz_cnt_q + 32'd1;
        end
      end
      S_DEAD: state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase

    // The current eat has already scored with the old chain value
    if (i_energizers_eaten) chain_d = 2'd0;

    // Snapshots are cleared too, so the first tick afterwards sees a zero history
    if (i_ghost_reload) begin
      state_d     = S_IDLE;
      chain_d     = 2'd0;
      kill_d      = 4'd0;
      eat_d       = 4'd0;
      frz_cnt_d   = 32'd0;
      eaten_d     = 4'd0;
      dead_d      = 1'b0;
      score_vld_d = 1'b0;
      score_add_d = 12'd0;
      px_d        = '0;
      py_d        = '0;
      for (int k = 0; k < 4; k++) begin
        gx_d[k] = '0;
        gy_d[k] = '0;
      end
`ifdef GHOST_COLLISION_CROSS_EN
      ppx_d = '0;
      ppy_d = '0;
      for (int k = 0; k < 4; k++) begin
        pgx_d[k] = '0;
        pgy_d[k] = '0;
      end
`endif
    end

    freeze_d = (state_d == S_FREEZE);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      for (int k = 0; k < 4; k++) begin
        gx_q[k]  <= '0;
        gy_q[k]  <= '0;
        gst_q[k] <= 4'd0;
      end
      kill_q      <= 4'd0;
      eat_q       <= 4'd0;
      chain_q     <= 2'd0;
      frz_cnt_q   <= 32'd0;
      eaten_q     <= 4'd0;
      dead_q      <= 1'b0;
      score_vld_q <= 1'b0;
      score_add_q <= 12'd0;
      freeze_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GHOST_COLLISION_CROSS_EN
      ppx_q       <= '0;
      ppy_q       <= '0;
      for (int k = 0; k < 4; k++) begin
        pgx_q[k] <= '0;
        pgy_q[k] <= '0;
      end
`endif
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      gst_q       <= gst_d;
      kill_q      <= kill_d;
      eat_q       <= eat_d;
      chain_q     <= chain_d;
      frz_cnt_q   <= frz_cnt_d;
      eaten_q     <= eaten_d;
      dead_q      <= dead_d;
      score_vld_q <= score_vld_d;
      score_add_q <= score_add_d;
      freeze_q    <= freeze_d;
      busy_q      <= busy_d;
`ifdef GHOST_COLLISION_CROSS_EN
      ppx_q       <= ppx_d;
      ppy_q       <= ppy_d;
      pgx_q       <= pgx_d;
      pgy_q       <= pgy_d;
`endif
    end
  end

  assign o_blinky_eaten = eaten_q[0];
  assign o_pinky_eaten  = eaten_q[1];
  assign o_inky_eaten   = eaten_q[2];
  assign o_clyde_eaten  = eaten_q[3];
  assign o_pacman_dead  = dead_q;
  assign o_score_valid  = score_vld_q;
  assign o_score_add    = score_add_q;
  assign o_freeze       = freeze_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_ghost_collision_unit.sv
// Bench for ghost_collision_unit: two instances (with and without freeze)
// share one stimulus stream; a per-instance reference model predicts pulses
// and per-cycle busy/freeze levels, and a negedge monitor compares them.
`timescale 1ns/1ps
module tb_ghost_collision_unit;

  localparam int unsigned TW  = 6;
  localparam int unsigned FC0 = 4;
  localparam logic [3:0] ST_SCATTER = 4'd0;
  localparam logic [3:0] ST_CHASE   = 4'd1;
  localparam logic [3:0] ST_FRIGHT  = 4'd2;
  localparam logic [3:0] ST_EYES    = 4'd8;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          tick = 1'b0, reload = 1'b0, energ = 1'b0;
  logic [TW-1:0] pac_x = '0, pac_y = '0;
  logic [TW-1:0] gx [4];
  logic [TW-1:0] gy [4];
  logic [3:0]    gst [4];

  logic [1:0][3:0]  eaten;
  logic [1:0]       dead, sv, frz, busy;
  logic [1:0][11:0] sadd;

  ghost_collision_unit #(.FREEZE_CYCLES(FC0), .TILE_W(TW)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_ghost_reload(reload),
    .i_energizers_eaten(energ), .i_pac_x(pac_x), .i_pac_y(pac_y),
    .i_blinky_x(gx[0]), .i_blinky_y(gy[0]), .i_pinky_x(gx[1]), .i_pinky_y(gy[1]),
    .i_inky_x(gx[2]), .i_inky_y(gy[2]), .i_clyde_x(gx[3]), .i_clyde_y(gy[3]),
    .i_blinky_state(gst[0]), .i_pinky_state(gst[1]),
    .i_inky_state(gst[2]), .i_clyde_state(gst[3]),
    .o_blinky_eaten(eaten[0][0]), .o_pinky_eaten(eaten[0][1]),
    .o_inky_eaten(eaten[0][2]), .o_clyde_eaten(eaten[0][3]),
    .o_pacman_dead(dead[0]), .o_score_valid(sv[0]), .o_score_add(sadd[0]),
    .o_freeze(frz[0]), .o_busy(busy[0]));

  ghost_collision_unit #(.FREEZE_CYCLES(0), .TILE_W(TW)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_ghost_reload(reload),
    .i_energizers_eaten(energ), .i_pac_x(pac_x), .i_pac_y(pac_y),
    .i_blinky_x(gx[0]), .i_blinky_y(gy[0]), .i_pinky_x(gx[1]), .i_pinky_y(gy[1]),
    .i_inky_x(gx[2]), .i_inky_y(gy[2]), .i_clyde_x(gx[3]), .i_clyde_y(gy[3]),
    .i_blinky_state(gst[0]), .i_pinky_state(gst[1]),
    .i_inky_state(gst[2]), .i_clyde_state(gst[3]),
    .o_blinky_eaten(eaten[1][0]), .o_pinky_eaten(eaten[1][1]),
    .o_inky_eaten(eaten[1][2]), .o_clyde_eaten(eaten[1][3]),
    .o_pacman_dead(dead[1]), .o_score_valid(sv[1]), .o_score_add(sadd[1]),
    .o_freeze(frz[1]), .o_busy(busy[1]));

  typedef struct {
    int          cyc;
    logic        dead;
    logic [3:0]  eaten;
    logic        sv;
    logic [11:0] sadd;
  } pulse_t;

  typedef struct {
    int   cyc;
    logic busy;
    logic frz;
  } lvl_t;

  pulse_t pq0[$], pq1[$];
  lvl_t   lq0[$], lq1[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit run   = 1'b0;

  // Reference model state, one set per instance
  int            chain [2];
  bit            mdead [2];
  bit            pend [2];
  int            pend_t [2];
  logic [3:0]    pkill [2];
  logic [3:0]    peat [2];
  int            ready [2];
  int            frz_from [2];
  logic [TW-1:0] ppx [2];
  logic [TW-1:0] ppy [2];
  logic [TW-1:0] pgx [2][4];
  logic [TW-1:0] pgy [2][4];

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int i, input int fc);
    pulse_t p;
    lvl_t   l;
    logic [3:0] km, em;
    bit hit;
    int lo;
    if (reload) begin
      pend[i] = 0; chain[i] = 0; mdead[i] = 0; ready[i] = cyc + 1; frz_from[i] = NEVER;
      ppx[i] = '0; ppy[i] = '0;
      for (int k = 0; k < 4; k++) begin pgx[i][k] = '0; pgy[i][k] = '0; end
    end else begin
      if (pend[i] && cyc == pend_t[i] + 5) begin
        pend[i] = 0;
        if (pkill[i] != 4'd0) begin
          p = '{cyc: cyc + 1, dead: 1'b1, eaten: 4'd0, sv: 1'b0, sadd: 12'd0};
          if (i == 0) pq0.push_back(p); else pq1.push_back(p);
          mdead[i] = 1;
        end else if (peat[i] != 4'd0) begin
          lo = 0;
          while (peat[i][lo] == 1'b0) lo++;
          p = '{cyc: cyc + 1, dead: 1'b0, eaten: 4'(1 << lo), sv: 1'b1,
                sadd: 12'(200 * (2 ** chain[i]))};
          if (i == 0) pq0.push_back(p); else pq1.push_back(p);
          ready[i]    = cyc + 1 + fc;
          frz_from[i] = cyc + 1;
          chain[i]    = (chain[i] < 3) ? chain[i] + 1 : 3;
        end
      end
      if (energ) chain[i] = 0;
      if (tick && !mdead[i] && !pend[i] && cyc >= ready[i]) begin
        km = 4'd0; em = 4'd0;
        for (int k = 0; k < 4; k++) begin
          hit = (gx[k] == pac_x) && (gy[k] == pac_y);
`ifdef GHOST_COLLISION_CROSS_EN
          if (pac_x == pgx[i][k] && pac_y == pgy[i][k] && gx[k] == ppx[i] && gy[k] == ppy[i])
            hit = 1;
`endif
          if (hit && (gst[k] == ST_CHASE || gst[k] == ST_SCATTER)) km[k] = 1'b1;
          if (hit && gst[k] == ST_FRIGHT) em[k] = 1'b1;
        end
        pkill[i] = km; peat[i] = em; pend[i] = 1; pend_t[i] = cyc;
        ready[i] = cyc + 6; frz_from[i] = NEVER;
        ppx[i] = pac_x; ppy[i] = pac_y;
        for (int k = 0; k < 4; k++) begin pgx[i][k] = gx[k]; pgy[i][k] = gy[k]; end
      end
    end
    l.cyc  = cyc + 1;
    l.busy = mdead[i] || pend[i] || (cyc + 1 < ready[i]);
    l.frz  = !mdead[i] && (cyc + 1 >= frz_from[i]) && (cyc + 1 < ready[i]);
    if (i == 0) lq0.push_back(l); else lq1.push_back(l);
  endtask

  function automatic int pfront(input int i);
    if (i == 0) return (pq0.size() > 0) ? pq0[0].cyc : -1;
    return (pq1.size() > 0) ? pq1[0].cyc : -1;
  endfunction

  function automatic pulse_t ppop(input int i);
    if (i == 0) return pq0.pop_front();
    return pq1.pop_front();
  endfunction

  task automatic mon_inst(input int i);
    lvl_t   l;
    pulse_t p;
    bit     have;
    have = 0;
    if (i == 0 && lq0.size() > 0 && lq0[0].cyc == cyc) begin l = lq0.pop_front(); have = 1; end
    if (i == 1 && lq1.size() > 0 && lq1[0].cyc == cyc) begin l = lq1.pop_front(); have = 1; end
    if (have) begin
      chk("busy", i, 32'(busy[i]), 32'(l.busy));
      chk("freeze", i, 32'(frz[i]), 32'(l.frz));
    end
    while (pfront(i) >= 0 && pfront(i) < cyc) begin
      p = ppop(i);
      tests++; fails++;
      $display("FAIL pulse_missed inst%0d cyc=%0d got=none want=pulse@%0d", i, cyc, p.cyc);
    end
    if (pfront(i) == cyc) begin
      p = ppop(i);
      chk("dead", i, 32'(dead[i]), 32'(p.dead));
      chk("eaten", i, 32'(eaten[i]), 32'(p.eaten));
      chk("score_valid", i, 32'(sv[i]), 32'(p.sv));
      if (p.sv) chk("score_add", i, 32'(sadd[i]), 32'(p.sadd));
    end else if (dead[i] || sv[i] || eaten[i] != 4'd0) begin
      tests++; fails++;
      $display("FAIL unexpected_pulse inst%0d cyc=%0d got=dead%0d eaten%0h sv%0d want=none",
               i, cyc, dead[i], eaten[i], sv[i]);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      mon_inst(0);
      mon_inst(1);
    end
  end

  task automatic step(input bit t, input bit r, input bit e);
    tick = t; reload = r; energ = e;
    model_step(0, FC0);
    model_step(1, 0);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic place(input int k, input int x, input int y, input logic [3:0] s);
    gx[k] = TW'(x); gy[k] = TW'(y); gst[k] = s;
  endtask

  function automatic logic [3:0] rand_st();
    case ($urandom_range(4))
      0: return ST_SCATTER;
      1: return ST_CHASE;
      2, 3: return ST_FRIGHT;
      default: return 4'($urandom_range(15));
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) place(k, 30, 30, ST_EYES);
    for (int i = 0; i < 2; i++) begin
      chain[i] = 0; mdead[i] = 0; pend[i] = 0; pend_t[i] = 0; ready[i] = 0;
      frz_from[i] = NEVER; pkill[i] = 4'd0; peat[i] = 4'd0; ppx[i] = '0; ppy[i] = '0;
      for (int k = 0; k < 4; k++) begin pgx[i][k] = '0; pgy[i][k] = '0; end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_eaten", i, 32'(eaten[i]), 32'd0);
      chk("rst_dead", i, 32'(dead[i]), 32'd0);
      chk("rst_sv", i, 32'(sv[i]), 32'd0);
      chk("rst_sadd", i, 32'(sadd[i]), 32'd0);
      chk("rst_freeze", i, 32'(frz[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
    end
    rst_n = 1'b1;
    cyc = 0;
    run = 1'b1;

    // Single inky eat
    pac_x = 5; pac_y = 5;
    place(2, 5, 5, ST_FRIGHT);
    step(1, 0, 0); idle(12);
    // Chain 200/400/800/1600/1600, then energizer restarts at 200
    step(0, 0, 1);
    repeat (5) begin step(1, 0, 0); idle(12); end
    step(0, 0, 1);
    step(1, 0, 0); idle(12);
    // Kill wins over eat; DEAD holds until reload
    place(2, 30, 30, ST_EYES); place(0, 5, 5, ST_FRIGHT); place(1, 5, 5, ST_CHASE);
    step(1, 0, 0); idle(10); step(0, 1, 0); idle(2);
    // Two frightened ghosts; retick at T+6
    place(0, 30, 30, ST_EYES); place(1, 5, 5, ST_FRIGHT); place(3, 5, 5, ST_FRIGHT);
    step(1, 0, 0); idle(5); step(1, 0, 0); idle(14);
    // Reload mid-scan, then chain restarts
    step(1, 0, 0); idle(2); step(0, 1, 0); idle(3); step(1, 0, 0); idle(12);
    // Tile swap between ticks
    place(1, 30, 30, ST_EYES); place(3, 30, 30, ST_EYES);
    pac_x = 4; pac_y = 4; place(0, 5, 4, ST_CHASE);
    step(1, 0, 0); idle(12);
    pac_x = 5; pac_y = 4; place(0, 4, 4, ST_CHASE);
    step(1, 0, 0); idle(12); step(0, 1, 0); idle(2);

    // Randomized traffic on a small grid so matches are frequent
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(3) == 0) begin
        pac_x = TW'($urandom_range(2)); pac_y = TW'($urandom_range(2));
        for (int k = 0; k < 4; k++)
          place(k, int'($urandom_range(2)), int'($urandom_range(2)), rand_st());
      end
      step($urandom_range(3) == 0, $urandom_range(39) == 0, $urandom_range(29) == 0);
    end
    idle(30);

    chk("pulse_queue_empty", 0, 32'(pq0.size()), 32'd0);
    chk("pulse_queue_empty", 1, 32'(pq1.size()), 32'd0);
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
